pe_input_mapper: RTL

//  Registered, parametrised mapper between the weight/activation buffer read ports and the PE array inputs.

---
 rtl/pe_input_mapper.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_input_mapper.sv
// ---------------------------------------------------------------------------
// pe_input_mapper
//   Registered mapper from the weight/activation buffer read ports to the PE
//   array inputs. One buffer line is accepted per valid/ready handshake and
//   unpacked into 1, 2 or 4 PE beats (16/8/4-bit elements). Weights map one
//   element per PE; activations are broadcast down each PE column.
//
//   Optional feature macro: ZERO_SKIP_EN
//     defined   : beats whose weights are all zero are dropped and counted in
//                 skip_cnt (saturating); the last beat of a tile is always
//                 presented so tile_done still fires.
//     undefined : every beat is presented, skip_cnt is tied to zero.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   prec_mode[1:0]        0=16b 1=8b 2=4b 3=16b; sampled on line accept
//   signed_mode           sign- (1) or zero- (0) extend sub-words
//   in_valid/in_ready     buffer line handshake
//   in_last               line is the last of the current tile
//   wei_line, act_line    packed weight / activation lines
//   out_valid/out_ready   PE beat handshake (out_ready = mac_en)
//   wei_out, act_out      per-PE operands, PE p at [p*MAX_PREC +: MAX_PREC]
//   out_last              beat is the last beat of the tile
//   tile_done             one-cycle pulse after the out_last beat is taken
//   sparse_stall          out_valid & ~out_ready
//   skip_cnt              number of beats dropped by zero-skip
// ---------------------------------------------------------------------------
module pe_input_mapper #(
   parameter int unsigned PE_ROWS  = 4,
   parameter int unsigned PE_COLS  = 4,
   parameter int unsigned MAX_PREC = 16,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [1:0]                            prec_mode,
   input  logic                                  signed_mode,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic                                  in_last,
   input  logic [PE_ROWS*PE_COLS*MAX_PREC-1:0]   wei_line,
   input  logic [PE_COLS*MAX_PREC-1:0]           act_line,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [PE_ROWS*PE_COLS*MAX_PREC-1:0]   wei_out,
   output logic [PE_ROWS*PE_COLS*MAX_PREC-1:0]   act_out,
   output logic                                  out_last,
   output logic                                  tile_done,
   output logic                                  sparse_stall,
   output logic [CNT_W-1:0]                      skip_cnt
);

   localparam int unsigned NUM_PES = PE_ROWS * PE_COLS;
   localparam int unsigned LW      = NUM_PES * MAX_PREC;
   localparam int unsigned AW      = PE_COLS * MAX_PREC;
   localparam int unsigned H       = MAX_PREC / 2;
   localparam int unsigned Q       = MAX_PREC / 4;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   // Index of the last beat of a line for a (normalised) precision code.
   function automatic logic [1:0] f_nbl(input logic [1:0] prec);
      case (prec)
         2'd1:    return 2'd1;
         2'd2:    return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Extract element idx of the active width and extend it to MAX_PREC.
   function automatic logic [MAX_PREC-1:0] f_elem(input logic [LW-1:0]  line,
                                                  input logic [1:0]     prec,
                                                  input logic           sgn,
                                                  input int unsigned    idx);
      logic [H-1:0]        eh;
      logic [Q-1:0]        eq;
      logic [MAX_PREC-1:0] res;
      eh  = '0;
      eq  = '0;
      res = '0;
      case (prec)
         2'd1: begin
            eh  = H'(line >> (idx * H));
            res = sgn ? {{(MAX_PREC-H){eh[H-1]}}, eh} : {{(MAX_PREC-H){1'b0}}, eh};
         end
         2'd2: begin
            eq  = Q'(line >> (idx * Q));
            res = sgn ? {{(MAX_PREC-Q){eq[Q-1]}}, eq} : {{(MAX_PREC-Q){1'b0}}, eq};
         end
         default: res = MAX_PREC'(line >> (idx * MAX_PREC));
      endcase
      return res;
   endfunction

   // Weight beat: element beat*NUM_PES+p goes to PE p.
   function automatic logic [LW-1:0] f_wei(input logic [LW-1:0] line,
                                           input logic [1:0]    prec,
                                           input logic          sgn,
                                           input logic [1:0]    beat);
      logic [LW-1:0] res;
      res = '0;
      for (int unsigned p = 0; p < NUM_PES; p++) begin
         res = res | (LW'(f_elem(line, prec, sgn, 32'(beat) * NUM_PES + p)) << (p * MAX_PREC));
      end
      return res;
   endfunction

   // Activation beat: element beat*PE_COLS+c is broadcast to every PE of column c.
   function automatic logic [LW-1:0] f_act(input logic [AW-1:0] line,
                                           input logic [1:0]    prec,
                                           input logic          sgn,
                                           input logic [1:0]    beat);
      logic [LW-1:0] res;
      res = '0;
      for (int unsigned p = 0; p < NUM_PES; p++) begin
         res = res | (LW'(f_elem(LW'(line), prec, sgn,
                                 32'(beat) * PE_COLS + (p % PE_COLS))) << (p * MAX_PREC));
      end
      return res;
   endfunction

   state_t          r_state;
   state_t          w_state_nxt;
   logic [LW-1:0]   r_wei_line;
   logic [AW-1:0]   r_act_line;
   logic [1:0]      r_prec;
   logic            r_sgn;
   logic            r_last;
   logic [1:0]      r_beat;
   logic [LW-1:0]   r_wei_out;
   logic [LW-1:0]   r_act_out;
   logic            r_out_last;
   logic            r_tile_done;

   logic            w_acc;
   logic            w_last_beat;
   logic            w_in_ready;
   logic            w_load_new;
   logic            w_adv;
   logic            w_take;
   logic [1:0]      w_in_prec;
   logic [LW-1:0]   w_src_wei;
   logic [AW-1:0]   w_src_act;
   logic [1:0]      w_src_prec;
   logic            w_src_sgn;
   logic            w_src_last;
   logic [1:0]      w_src_nbl;
   logic [1:0]      w_start;
   logic [1:0]      w_sel;
   logic            w_found;
   logic [LW-1:0]   w_beat_wei;
   logic [LW-1:0]   w_beat_act;

`ifdef ZERO_SKIP_EN
   localparam int unsigned CW1 = CNT_W + 1;
   logic [3:0]      w_zero;
   logic [2:0]      w_skip;
   logic [CNT_W:0]  w_sum;
   logic [CNT_W-1:0] r_skip_cnt;
`endif

   // Reserved precision code 3 behaves exactly like 16b.
   assign w_in_prec = (prec_mode == 2'd3) ? 2'd0 : prec_mode;

   always_comb begin
      w_acc       = (r_state == S_ISSUE) && out_ready;
      w_last_beat = (r_beat == f_nbl(r_prec));
      w_in_ready  = (r_state == S_IDLE) || (w_acc && w_last_beat);
      w_load_new  = in_valid && w_in_ready;
      w_adv       = w_acc && !w_last_beat;
      w_take      = w_load_new || w_adv;

      // Next beat comes either from the incoming line (beat 0) or from the
      // latched line (beat+1); a single extraction path serves both.
      if (w_load_new) begin
         w_src_wei  = wei_line;
         w_src_act  = act_line;
         w_src_prec = w_in_prec;
         w_src_sgn  = signed_mode;
         w_src_last = in_last;
         w_start    = 2'd0;
      end else begin
         w_src_wei  = r_wei_line;
         w_src_act  = r_act_line;
         w_src_prec = r_prec;
         w_src_sgn  = r_sgn;
         w_src_last = r_last;
         w_start    = r_beat + 2'd1;
      end
      w_src_nbl = f_nbl(w_src_prec);

`ifdef ZERO_SKIP_EN
      // Find the first beat at or after w_start that has a nonzero weight,
      // counting the dropped ones. The final beat of a tile is never dropped.
      w_zero  = '0;
      w_skip  = '0;
      w_found = 1'b0;
      w_sel   = w_start;
      for (int unsigned k = 0; k < 4; k++) begin
         w_zero[k] = (f_wei(w_src_wei, w_src_prec, 1'b0, 2'(k)) == '0) &&
                     !(w_src_last && (2'(k) == w_src_nbl));
         if (!w_found && (k >= 32'(w_start)) && (k <= 32'(w_src_nbl))) begin
            if (w_zero[k]) begin
               w_skip = w_skip + 3'd1;
            end else begin
               w_found = 1'b1;
               w_sel   = 2'(k);
            end
         end
      end
      w_sum = {1'b0, r_skip_cnt} + CW1'(w_skip);
`else
      w_found = 1'b1;
      w_sel   = w_start;
`endif

      w_beat_wei = f_wei(w_src_wei, w_src_prec, w_src_sgn, w_sel);
      w_beat_act = f_act(w_src_act, w_src_prec, w_src_sgn, w_sel);

      w_state_nxt = r_state;
      if (w_take) begin
         w_state_nxt = w_found ? S_ISSUE : S_IDLE;
      end else if (w_acc) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wei_line  <= '0;
         r_act_line  <= '0;
         r_prec      <= '0;
         r_sgn       <= 1'b0;
         r_last      <= 1'b0;
         r_beat      <= '0;
         r_wei_out   <= '0;
         r_act_out   <= '0;
         r_out_last  <= 1'b0;
         r_tile_done <= 1'b0;
      end else begin
         if (w_load_new) begin
            r_wei_line <= wei_line;
            r_act_line <= act_line;
            r_prec     <= w_in_prec;
            r_sgn      <= signed_mode;
            r_last     <= in_last;
         end
         // Output registers only move on a load, so a stalled beat is held.
         if (w_take && w_found) begin
            r_beat     <= w_sel;
            r_wei_out  <= w_beat_wei;
            r_act_out  <= w_beat_act;
            r_out_last <= w_src_last && (w_sel == w_src_nbl);
         end
         r_tile_done <= w_acc && r_out_last;
      end
   end

`ifdef ZERO_SKIP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skip_cnt <= '0;
      end else if (w_take) begin
         r_skip_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end
   end
   assign skip_cnt = r_skip_cnt;
`else
   assign skip_cnt = '0;
`endif

   assign in_ready     = w_in_ready;
   assign out_valid    = (r_state == S_ISSUE);
   assign wei_out      = r_wei_out;
   assign act_out      = r_act_out;
   assign out_last     = r_out_last && out_valid;
   assign tile_done    = r_tile_done;
   assign sparse_stall = out_valid && !out_ready;

endmodule
